id_stage_pipe: RTL and testbench

Next-generation decode stage for the core. It merges instruction decode, immediate generation and the register file with a registered ID/EX pipeline boundary. It adds load-use hazard stalling, flush on a taken branch or jump, and optional write-back-to-read bypass. It sits between IF and EX, and all ex_* outputs feed EX directly.

---
 rtl/id_stage_pipe.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage: instruction decode, immediate generation, register file and ID/EX register,
// with load-use stall, branch/jump flush and optional write-back bypass.
package id_stage_pipe_pkg;
    typedef enum logic [2:0] {
        ALUOP_ADD    = 3'd0,
        ALUOP_SUB    = 3'd1,
        ALUOP_FUNCT3 = 3'd2,
        ALUOP_FUNCT7 = 3'd3,
        ALUOP_PASS_B = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic    valid;
        logic    src_a;
        logic    src_b;
        logic    branch;
        logic    jump;
        logic    mem_write;
        logic    mem_read;
        logic    reg_write;
        logic    illegal;
        alu_op_e alu_op;
        wb_sel_e wb_sel;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                         ALUOP_ADD, WB_ALU};
endpackage

module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned WB_BYPASS      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid_i,
    input  logic [31:0]               instruction_i,
    input  logic [DATA_WIDTH-1:0]     pc_i,
    output logic                      id_ready_o,
    input  logic                      flush_i,
    input  logic                      WB_RegWrite_i,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    output logic                      ex_valid_o,
    output logic [DATA_WIDTH-1:0]     ex_pc_o,
    output logic [DATA_WIDTH-1:0]     ex_immediate_o,
    output logic [DATA_WIDTH-1:0]     ex_rd_data1_o,
    output logic [DATA_WIDTH-1:0]     ex_rd_data2_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic [2:0]                ex_funct3_o,
    output logic                      ex_funct7b5_o,
    output logic                      ex_ALUSrcA_o,
    output logic                      ex_ALUSrcB_o,
    output logic                      ex_Branch_o,
    output logic                      ex_Jump_o,
    output logic                      ex_MemWrite_o,
    output logic                      ex_MemRead_o,
    output logic                      ex_RegWrite_o,
    output logic                      ex_illegal_o,
    output alu_op_e                   ex_ALUOp_o,
    output wb_sel_e                   ex_WBSel_o
);

    localparam logic [6:0] OP_NONE   = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1_c, rs2_c, rd_c;
    logic [31:0]               imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction_i[6:0];
    assign rd_c   = REG_ADDR_WIDTH'(instruction_i[11:7]);
    assign rs1_c  = REG_ADDR_WIDTH'(instruction_i[19:15]);
    assign rs2_c  = REG_ADDR_WIDTH'(instruction_i[24:20]);

    assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                    instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign imm_u = {instruction_i[31:12], 12'b0};
    assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                    instruction_i[20], instruction_i[30:21], 1'b0};

    // Opcode decode: controls, immediate select and which source registers are live
    ex_ctrl_t    dec_ctrl;
    logic        use_rs1, use_rs2;
    logic [31:0] imm32;

    always_comb begin
        dec_ctrl = CTRL_BUBBLE;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        imm32    = '0;
        case (opcode)
            OP_R: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.alu_op    = ALUOP_FUNCT7;
                dec_ctrl.reg_write = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
            end
            OP_IMM: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.alu_op    = ALUOP_FUNCT3;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                use_rs1            = 1'b1;
                imm32              = imm_i;
            end
            OP_LOAD: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_MEM;
                use_rs1            = 1'b1;
                imm32              = imm_i;
            end
            OP_STORE: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                imm32              = imm_s;
            end
            OP_BRANCH: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.alu_op    = ALUOP_SUB;
                dec_ctrl.branch    = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                imm32              = imm_b;
            end
            OP_LUI: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.src_a     = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.alu_op    = ALUOP_PASS_B;
                dec_ctrl.reg_write = 1'b1;
                imm32              = imm_u;
            end
            OP_AUIPC: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.src_a     = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm32              = imm_u;
            end
            OP_JAL: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.src_a     = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                imm32              = imm_j;
            end
            OP_JALR: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.src_b     = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel    = WB_PC4;
                use_rs1            = 1'b1;
                imm32              = imm_i;
            end
            OP_NONE: begin
                dec_ctrl = CTRL_BUBBLE;
            end
            default: begin
                dec_ctrl.valid   = 1'b1;
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Register file; x0 is never written so it reads as zero
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (WB_RegWrite_i && wr_addr_i != '0 && 32'(wr_addr_i) < NUM_REGS) begin
            rf_q[wr_addr_i] <= wr_data_i;
        end
    end

    logic [DATA_WIDTH-1:0] rd_data1_c, rd_data2_c;

    always_comb begin
        rd_data1_c = '0;
        rd_data2_c = '0;
        if (rs1_c != '0 && 32'(rs1_c) < NUM_REGS) begin
            rd_data1_c = rf_q[rs1_c];
        end
        if (rs2_c != '0 && 32'(rs2_c) < NUM_REGS) begin
            rd_data2_c = rf_q[rs2_c];
        end
        if (WB_BYPASS != 0 && WB_RegWrite_i && rs1_c != '0 && wr_addr_i == rs1_c) begin
            rd_data1_c = wr_data_i;
        end
        if (WB_BYPASS != 0 && WB_RegWrite_i && rs2_c != '0 && wr_addr_i == rs2_c) begin
            rd_data2_c = wr_data_i;
        end
    end

    // Load-use hazard against the instruction currently in EX
    ex_ctrl_t ex_ctrl_q;
    logic     stall_c;
    logic     issue_c;

    assign stall_c = if_valid_i && ex_ctrl_q.valid && ex_ctrl_q.mem_read && ex_rd_addr_o != '0
                     && ((use_rs1 && rs1_c == ex_rd_addr_o) || (use_rs2 && rs2_c == ex_rd_addr_o));
    assign id_ready_o = !stall_c || flush_i;
    assign issue_c    = !flush_i && if_valid_i && !stall_c && dec_ctrl.valid;

    ex_ctrl_t                  ctrl_nxt;
    logic [DATA_WIDTH-1:0]     pc_nxt, imm_nxt, rd_data1_nxt, rd_data2_nxt;
    logic [REG_ADDR_WIDTH-1:0] rs1_nxt, rs2_nxt, rd_nxt;
    logic [2:0]                funct3_nxt;
    logic                      funct7b5_nxt;

    always_comb begin
        ctrl_nxt     = CTRL_BUBBLE;
        pc_nxt       = '0;
        imm_nxt      = '0;
        rd_data1_nxt = '0;
        rd_data2_nxt = '0;
        rs1_nxt      = '0;
        rs2_nxt      = '0;
        rd_nxt       = '0;
        funct3_nxt   = '0;
        funct7b5_nxt = 1'b0;
        if (issue_c) begin
            ctrl_nxt     = dec_ctrl;
            pc_nxt       = pc_i;
            imm_nxt      = DATA_WIDTH'($signed(imm32));
            rd_data1_nxt = rd_data1_c;
            rd_data2_nxt = rd_data2_c;
            rs1_nxt      = rs1_c;
            rs2_nxt      = rs2_c;
            rd_nxt       = rd_c;
            funct3_nxt   = instruction_i[14:12];
            funct7b5_nxt = instruction_i[30];
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q      <= CTRL_BUBBLE;
            ex_pc_o        <= '0;
            ex_immediate_o <= '0;
            ex_rd_data1_o  <= '0;
            ex_rd_data2_o  <= '0;
            ex_rs1_addr_o  <= '0;
            ex_rs2_addr_o  <= '0;
            ex_rd_addr_o   <= '0;
            ex_funct3_o    <= '0;
            ex_funct7b5_o  <= 1'b0;
        end else begin
            ex_ctrl_q      <= ctrl_nxt;
            ex_pc_o        <= pc_nxt;
            ex_immediate_o <= imm_nxt;
            ex_rd_data1_o  <= rd_data1_nxt;
            ex_rd_data2_o  <= rd_data2_nxt;
            ex_rs1_addr_o  <= rs1_nxt;
            ex_rs2_addr_o  <= rs2_nxt;
            ex_rd_addr_o   <= rd_nxt;
            ex_funct3_o    <= funct3_nxt;
            ex_funct7b5_o  <= funct7b5_nxt;
        end
    end

    assign ex_valid_o    = ex_ctrl_q.valid;
    assign ex_ALUSrcA_o  = ex_ctrl_q.src_a;
    assign ex_ALUSrcB_o  = ex_ctrl_q.src_b;
    assign ex_Branch_o   = ex_ctrl_q.branch;
    assign ex_Jump_o     = ex_ctrl_q.jump;
    assign ex_MemWrite_o = ex_ctrl_q.mem_write;
    assign ex_MemRead_o  = ex_ctrl_q.mem_read;
    assign ex_RegWrite_o = ex_ctrl_q.reg_write;
    assign ex_illegal_o  = ex_ctrl_q.illegal;
    assign ex_ALUOp_o    = ex_ctrl_q.alu_op;
    assign ex_WBSel_o    = ex_ctrl_q.wb_sel;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; a second instance with the bypass disabled shares all inputs.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        id_ready, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_f3;
    logic        ex_f7b5, ex_srca, ex_srcb, ex_br, ex_jmp, ex_mw, ex_mr, ex_rw, ex_ill;
    alu_op_e     ex_aluop;
    wb_sel_e     ex_wbsel;

    logic        nb_id_ready, nb_ex_valid;
    logic [31:0] nb_ex_pc, nb_ex_imm, nb_ex_rd1, nb_ex_rd2;
    logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [2:0]  nb_ex_f3;
    logic        nb_ex_f7b5, nb_ex_srca, nb_ex_srcb, nb_ex_br, nb_ex_jmp, nb_ex_mw, nb_ex_mr;
    logic        nb_ex_rw, nb_ex_ill;
    alu_op_e     nb_ex_aluop;
    wb_sel_e     nb_ex_wbsel;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.WB_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .instruction_i(instr), .pc_i(pc),
        .id_ready_o(id_ready), .flush_i(flush), .WB_RegWrite_i(wb_we), .wr_addr_i(wb_addr),
        .wr_data_i(wb_data), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_immediate_o(ex_imm),
        .ex_rd_data1_o(ex_rd1), .ex_rd_data2_o(ex_rd2), .ex_rs1_addr_o(ex_rs1),
        .ex_rs2_addr_o(ex_rs2), .ex_rd_addr_o(ex_rd), .ex_funct3_o(ex_f3),
        .ex_funct7b5_o(ex_f7b5), .ex_ALUSrcA_o(ex_srca), .ex_ALUSrcB_o(ex_srcb),
        .ex_Branch_o(ex_br), .ex_Jump_o(ex_jmp), .ex_MemWrite_o(ex_mw), .ex_MemRead_o(ex_mr),
        .ex_RegWrite_o(ex_rw), .ex_illegal_o(ex_ill), .ex_ALUOp_o(ex_aluop),
        .ex_WBSel_o(ex_wbsel)
    );

    id_stage_pipe #(.WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .instruction_i(instr), .pc_i(pc),
        .id_ready_o(nb_id_ready), .flush_i(flush), .WB_RegWrite_i(wb_we), .wr_addr_i(wb_addr),
        .wr_data_i(wb_data), .ex_valid_o(nb_ex_valid), .ex_pc_o(nb_ex_pc),
        .ex_immediate_o(nb_ex_imm), .ex_rd_data1_o(nb_ex_rd1), .ex_rd_data2_o(nb_ex_rd2),
        .ex_rs1_addr_o(nb_ex_rs1), .ex_rs2_addr_o(nb_ex_rs2), .ex_rd_addr_o(nb_ex_rd),
        .ex_funct3_o(nb_ex_f3), .ex_funct7b5_o(nb_ex_f7b5), .ex_ALUSrcA_o(nb_ex_srca),
        .ex_ALUSrcB_o(nb_ex_srcb), .ex_Branch_o(nb_ex_br), .ex_Jump_o(nb_ex_jmp),
        .ex_MemWrite_o(nb_ex_mw), .ex_MemRead_o(nb_ex_mr), .ex_RegWrite_o(nb_ex_rw),
        .ex_illegal_o(nb_ex_ill), .ex_ALUOp_o(nb_ex_aluop), .ex_WBSel_o(nb_ex_wbsel)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        if_valid = 1'b1;
        instr    = i;
        pc       = p;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_we   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    localparam logic [31:0] I_ADDI   = 32'h07B08113; // addi x2,x1,123
    localparam logic [31:0] I_ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADDIX0 = 32'h00000393; // addi x7,x0,0
    localparam logic [31:0] I_LW5    = 32'h0080A283; // lw   x5,8(x1)
    localparam logic [31:0] I_ADD6   = 32'h00128333; // add  x6,x5,x1
    localparam logic [31:0] I_LW0    = 32'h0080A003; // lw   x0,8(x1)
    localparam logic [31:0] I_ADD6Z  = 32'h00100333; // add  x6,x0,x1
    localparam logic [31:0] I_BEQ    = 32'h00208463; // beq  x1,x2,+8
    localparam logic [31:0] I_LUI    = 32'hABCDE337; // lui  x6,0xABCDE
    localparam logic [31:0] I_JAL    = 32'hFFDFF0EF; // jal  x1,-4
    localparam logic [31:0] I_BAD    = 32'h0000007F;

    initial begin
        rst_n = 1'b0;
        if_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_aluop", 64'(ex_aluop), 64'(ALUOP_ADD));
        check("rst_wbsel", 64'(ex_wbsel), 64'(WB_ALU));
        check("rst_pc", 64'(ex_pc), 64'd0);
        check("rst_ready", 64'(id_ready), 64'd1);
        rst_n = 1'b1;

        // Write x1=50, then addi x2,x1,123
        wb(1'b1, 5'd1, 32'd50);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        issue(I_ADDI, 32'h100);
        tick();
        check("addi_valid", 64'(ex_valid), 64'd1);
        check("addi_rd1", 64'(ex_rd1), 64'd50);
        check("addi_imm", 64'(ex_imm), 64'd123);
        check("addi_aluop", 64'(ex_aluop), 64'(ALUOP_FUNCT3));
        check("addi_srcb", 64'(ex_srcb), 64'd1);
        check("addi_wbsel", 64'(ex_wbsel), 64'(WB_ALU));
        check("addi_rd", 64'(ex_rd), 64'd2);
        check("addi_pc", 64'(ex_pc), 64'h100);

        // Same-cycle write-back of x2 while add x3,x1,x2 reads it
        if_valid = 1'b0;
        wb(1'b1, 5'd2, 32'd10);
        tick();
        issue(I_ADD3, 32'h104);
        wb(1'b1, 5'd2, 32'd25);
        tick();
        check("byp_rd2", 64'(ex_rd2), 64'd25);
        check("nobyp_rd2", 64'(nb_ex_rd2), 64'd10);
        check("byp_rd1", 64'(ex_rd1), 64'd50);
        check("add_aluop", 64'(ex_aluop), 64'(ALUOP_FUNCT7));
        check("add_srcb", 64'(ex_srcb), 64'd0);

        // x0 write is dropped and never bypassed
        issue(I_ADDIX0, 32'h108);
        wb(1'b1, 5'd0, 32'd99);
        tick();
        check("x0_byp", 64'(ex_rd1), 64'd0);
        wb(1'b0, 5'd0, 32'd0);
        tick();
        check("x0_read", 64'(ex_rd1), 64'd0);
        check("x0_read_nb", 64'(nb_ex_rd1), 64'd0);

        // Load-use: lw x5 then add x6,x5,x1
        issue(I_LW5, 32'h200);
        tick();
        check("lw_memrd", 64'(ex_mr), 64'd1);
        check("lw_wbsel", 64'(ex_wbsel), 64'(WB_MEM));
        check("lw_imm", 64'(ex_imm), 64'd8);
        issue(I_ADD6, 32'h204);
        #1;
        check("lu_stall", 64'(id_ready), 64'd0);
        tick();
        check("lu_bubble_v", 64'(ex_valid), 64'd0);
        check("lu_bubble_rw", 64'(ex_rw), 64'd0);
        check("lu_ready", 64'(id_ready), 64'd1);
        tick();
        check("lu_issue_v", 64'(ex_valid), 64'd1);
        check("lu_issue_pc", 64'(ex_pc), 64'h204);
        check("lu_issue_rd", 64'(ex_rd), 64'd6);

        // Load to x0 never stalls
        issue(I_LW0, 32'h300);
        tick();
        issue(I_ADD6Z, 32'h304);
        #1;
        check("lw0_ready", 64'(id_ready), 64'd1);
        tick();
        check("lw0_next_pc", 64'(ex_pc), 64'h304);
        check("lw0_next_v", 64'(ex_valid), 64'd1);

        // Branch decode, then flushed branch
        issue(I_BEQ, 32'h400);
        tick();
        check("beq_br", 64'(ex_br), 64'd1);
        check("beq_aluop", 64'(ex_aluop), 64'(ALUOP_SUB));
        check("beq_imm", 64'(ex_imm), 64'd8);
        flush = 1'b1;
        tick();
        check("flush_v", 64'(ex_valid), 64'd0);
        check("flush_br", 64'(ex_br), 64'd0);
        check("flush_aluop", 64'(ex_aluop), 64'(ALUOP_ADD));
        check("flush_pc", 64'(ex_pc), 64'd0);

        // Flush during a load-use stall
        flush = 1'b0;
        issue(I_LW5, 32'h500);
        tick();
        issue(I_ADD6, 32'h504);
        flush = 1'b1;
        #1;
        check("flush_stall_ready", 64'(id_ready), 64'd1);
        tick();
        check("flush_stall_v", 64'(ex_valid), 64'd0);
        check("flush_stall_mr", 64'(ex_mr), 64'd0);
        flush = 1'b0;

        // U, J and illegal formats
        issue(I_LUI, 32'h600);
        tick();
        check("lui_imm", 64'(ex_imm), 64'hABCDE000);
        check("lui_aluop", 64'(ex_aluop), 64'(ALUOP_PASS_B));
        check("lui_srca", 64'(ex_srca), 64'd1);
        issue(I_JAL, 32'h604);
        tick();
        check("jal_imm", 64'(ex_imm), 64'hFFFFFFFC);
        check("jal_jump", 64'(ex_jmp), 64'd1);
        check("jal_wbsel", 64'(ex_wbsel), 64'(WB_PC4));
        issue(I_BAD, 32'h608);
        tick();
        check("ill_flag", 64'(ex_ill), 64'd1);
        check("ill_valid", 64'(ex_valid), 64'd1);
        check("ill_rw", 64'(ex_rw), 64'd0);

        // Mid-stream reset clears the register file
        if_valid = 1'b0;
        wb(1'b1, 5'd1, 32'd77);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        issue(I_ADDI, 32'h700);
        rst_n = 1'b0;
        #1;
        check("mrst_ready_in", 64'(id_ready), 64'd1);
        tick();
        check("mrst_valid", 64'(ex_valid), 64'd0);
        check("mrst_aluop", 64'(ex_aluop), 64'(ALUOP_ADD));
        check("mrst_ready", 64'(id_ready), 64'd1);
        rst_n = 1'b1;
        tick();
        check("mrst_x1", 64'(ex_rd1), 64'd0);
        check("mrst_x1_nb", 64'(nb_ex_rd1), 64'd0);
        check("mrst_v", 64'(ex_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
